// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a five-stage RISC-V pipeline: load-use stalls, MEM-stage redirects, data-memory waits.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LDSTALL  = 2'b01,
    MEMWAIT  = 2'b10,
    REDIRECT = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   load_use;
  logic   load_use_live;
  logic   redirect_taken;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // After a stall or redirect the ID/EX slot holds a bubble, so a match is stale.
  assign load_use_live  = load_use && ((state_q == RUN) || (state_q == MEMWAIT));
  assign redirect_taken = !rst && !mem_busy && mem_redirect;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = RUN;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
    end else if (mem_busy) begin
      // MEM instruction is held; WB gets a bubble so its write is not repeated.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_d     = MEMWAIT;
    end else if (mem_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = REDIRECT;
    end else if (load_use_live) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LDSTALL;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!rst && !pc_en && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
    if (redirect_taken && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  logic unused_perf;
  assign unused_perf  = redirect_taken;
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hand-computed enable/flush vectors, state and counters.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, mem_redirect, mem_busy;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;

  int n_cmp  = 0;
  int n_fail = 0;

  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  localparam logic [8:0] V_RST   = 9'b11111_1111;
  localparam logic [8:0] V_NORM  = 9'b11111_0000;
  localparam logic [8:0] V_BUSY  = 9'b00001_0001;
  localparam logic [8:0] V_REDIR = 9'b11111_1110;
  localparam logic [8:0] V_LDUSE = 9'b00111_0100;

  localparam logic [1:0] S_RUN = 2'b00, S_LDSTALL = 2'b01, S_MEMWAIT = 2'b10, S_REDIRECT = 2'b11;

  logic [8:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_redirect(mem_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic ld, input logic [4:0] rd, input logic redir, input logic busy);
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_is_load = ld; ex_rd = rd; mem_redirect = redir; mem_busy = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ctl_pre", 32'(ctl), 32'(V_RST));
    tick();
    chk("rst_state", 32'(state), 32'(S_RUN));
    chk("rst_ctl", 32'(ctl), 32'(V_RST));
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_events, 32'd0);
    rst = 1'b0;

    // plain advance
    drive(3, 1, 4, 1, 0, 3, 0, 0);
    chk("norm_ctl", 32'(ctl), 32'(V_NORM));
    tick();
    chk("norm_state", 32'(state), 32'(S_RUN));

    // lw x5 / add x6,x5,x7
    drive(5, 1, 7, 1, 1, 5, 0, 0);
    chk("lu_rs1_ctl", 32'(ctl), 32'(V_LDUSE));
    tick();
    chk("lu_state", 32'(state), 32'(S_LDSTALL));
    chk("lu_masked_ctl", 32'(ctl), 32'(V_NORM));
    chk("lu_stall_cnt", stall_cycles, PERF ? 32'd1 : 32'd0);
    tick();
    chk("lu_back_run", 32'(state), 32'(S_RUN));

    // lw x0: no hazard; rs2 match; rs2 match without use
    drive(0, 1, 0, 1, 1, 0, 0, 0);
    chk("lw_x0_ctl", 32'(ctl), 32'(V_NORM));
    drive(1, 1, 9, 1, 1, 9, 0, 0);
    chk("lu_rs2_ctl", 32'(ctl), 32'(V_LDUSE));
    drive(1, 1, 9, 0, 1, 9, 0, 0);
    chk("rs2_unused_ctl", 32'(ctl), 32'(V_NORM));
    drive(9, 1, 0, 0, 0, 9, 0, 0);
    chk("not_load_ctl", 32'(ctl), 32'(V_NORM));
    tick();
    chk("lw_x0_state", 32'(state), 32'(S_RUN));

    // single redirect, then load-use masked in REDIRECT
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("redir_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    chk("redir_state", 32'(state), 32'(S_REDIRECT));
    chk("redir_flush_cnt", flush_events, PERF ? 32'd1 : 32'd0);
    drive(5, 1, 0, 0, 1, 5, 0, 0);
    chk("redir_masked_ctl", 32'(ctl), 32'(V_NORM));
    tick();
    chk("redir_back_run", 32'(state), 32'(S_RUN));

    // busy 3 cycles with load-use pending, then one bubble
    do_reset();
    drive(5, 1, 0, 0, 1, 5, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy_ctl_%0d", i), 32'(ctl), 32'(V_BUSY));
      chk($sformatf("busy_state_%0d", i), 32'(state), (i == 0) ? 32'(S_RUN) : 32'(S_MEMWAIT));
      tick();
    end
    drive(5, 1, 0, 0, 1, 5, 0, 0);
    chk("busy_done_state", 32'(state), 32'(S_MEMWAIT));
    chk("busy_done_ctl", 32'(ctl), 32'(V_LDUSE));
    tick();
    chk("busy_lu_state", 32'(state), 32'(S_LDSTALL));
    chk("busy_stall_cnt", stall_cycles, PERF ? 32'd4 : 32'd0);

    // busy hides redirect; redirect fires on first non-busy cycle
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("busy_redir_ctl", 32'(ctl), 32'(V_BUSY));
    tick();
    chk("busy_redir_flush_cnt0", flush_events, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("late_redir_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    chk("late_redir_state", 32'(state), 32'(S_REDIRECT));
    chk("late_redir_flush_cnt", flush_events, PERF ? 32'd1 : 32'd0);
    chk("late_redir_stall_cnt", stall_cycles, PERF ? 32'd1 : 32'd0);
    // illegal redirect in REDIRECT follows the same priority
    chk("redir_in_redir_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    chk("redir_in_redir_state", 32'(state), 32'(S_REDIRECT));
    chk("redir_in_redir_cnt", flush_events, PERF ? 32'd2 : 32'd0);

    // reset while in LDSTALL
    do_reset();
    drive(5, 1, 0, 0, 1, 5, 0, 0);
    tick();
    chk("pre_rst_state", 32'(state), 32'(S_LDSTALL));
    rst = 1'b1;
    drive(5, 1, 0, 0, 1, 5, 1, 1);
    chk("mid_rst_ctl", 32'(ctl), 32'(V_RST));
    tick();
    chk("post_rst_state", 32'(state), 32'(S_RUN));
    chk("post_rst_stall_cnt", stall_cycles, 32'd0);
    chk("post_rst_flush_cnt", flush_events, 32'd0);
    rst = 1'b0;
    drive(5, 1, 0, 0, 1, 5, 0, 0);
    chk("post_rst_lu_ctl", 32'(ctl), 32'(V_LDUSE));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
